sm_arith_unit: RTL and testbench



---
 rtl/sm_arith_pkg.sv | 17 +
 rtl/sm_arith_unit_mag_core.sv | 35 +++
 rtl/sm_arith_unit.sv | 140 ++++++++++++++
 tb/tb_sm_arith_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sm_arith_pkg.sv
// Shared types and helpers for the sign-magnitude arithmetic unit.
// Optional build macro used by the top: SM_SATURATE_EN.
package sm_arith_pkg;

    typedef enum logic [1:0] {
        SM_ADD  = 2'd0,
        SM_SUB  = 2'd1,
        SM_GE   = 2'd2,
        SM_RSVD = 2'd3
    } sm_op_t;

    // A zero magnitude must always carry a positive sign.
    function automatic logic sm_neg_zero_fix(input logic sign, input logic mag_is_zero);
        return sign & ~mag_is_zero;
    endfunction

endpackage : sm_arith_pkg

// File: rtl/sm_arith_unit_mag_core.sv
// Unsigned magnitude datapath: adder with carry out, >= comparator,
// and a larger-minus-smaller subtractor.
module sm_mag_core
    import sm_arith_pkg::*;
#(
    parameter int MW = 3
) (
    input  logic [MW-1:0] ma,
    input  logic [MW-1:0] mb,
    output logic [MW-1:0] sum,
    output logic          carry,
    output logic          ge,
    output logic [MW-1:0] diff
);

    logic [MW:0] sum_ext_s;

    // Magnitude add; the extra bit is the overflow carry.
    always_comb begin
        sum_ext_s = {1'b0, ma} + {1'b0, mb};
        sum       = sum_ext_s[MW-1:0];
        carry     = sum_ext_s[MW];
    end

    // Compare, then subtract the smaller from the larger so no borrow exists.
    always_comb begin
        ge = (ma >= mb);
        if (ge) begin
            diff = ma - mb;
        end else begin
            diff = mb - ma;
        end
    end

endmodule : sm_mag_core

// File: rtl/sm_arith_unit.sv
// Registered sign-magnitude add / subtract / magnitude-compare slice, one cycle latency.
// Build macro SM_SATURATE_EN: saturate ADD/SUB overflow instead of wrapping.
module sm_arith_unit
    import sm_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             of
);

    localparam int MW = WIDTH - 1;

    sm_op_t           op_s;
    logic             sa_s;
    logic             sb_eff_s;
    logic [MW-1:0]    ma_s;
    logic [MW-1:0]    mb_s;
    logic [MW-1:0]    sum_s;
    logic [MW-1:0]    diff_s;
    logic             carry_s;
    logic             ge_s;
    logic             sign_s;
    logic [MW-1:0]    mag_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_of_s;

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             of_d;
    logic             of_q;
    logic             out_valid_d;
    logic             out_valid_q;

    assign op_s = sm_op_t'(op);
    assign sa_s = a[WIDTH-1];
    assign ma_s = a[MW-1:0];
    assign mb_s = b[MW-1:0];

    sm_mag_core #(
        .MW (MW)
    ) u_mag_core (
        .ma    (ma_s),
        .mb    (mb_s),
        .sum   (sum_s),
        .carry (carry_s),
        .ge    (ge_s),
        .diff  (diff_s)
    );

    // Effective sign of B: subtraction is addition of the negated operand.
    always_comb begin
        if (op_s == SM_SUB) begin
            sb_eff_s = ~b[WIDTH-1];
        end else begin
            sb_eff_s = b[WIDTH-1];
        end
    end

    // Op decode, sign selection, overflow handling and zero normalisation.
    always_comb begin
        sign_s    = 1'b0;
        mag_s     = {MW{1'b0}};
        alu_of_s  = 1'b0;
        alu_res_s = {WIDTH{1'b0}};
        case (op_s)
            SM_ADD, SM_SUB: begin
                if (sa_s == sb_eff_s) begin
                    sign_s   = sa_s;
                    alu_of_s = carry_s;
`ifdef SM_SATURATE_EN
                    if (carry_s) begin
                        mag_s = {MW{1'b1}};
                    end else begin
                        mag_s = sum_s;
                    end
`else
                    mag_s = sum_s;
`endif
                end else begin
                    // Opposite signs: the larger magnitude owns the sign.
                    if (ge_s) begin
                        sign_s = sa_s;
                    end else begin
                        sign_s = sb_eff_s;
                    end
                    mag_s    = diff_s;
                    alu_of_s = 1'b0;
                end
                alu_res_s = {sm_neg_zero_fix(sign_s, (mag_s == {MW{1'b0}})), mag_s};
            end
            SM_GE: begin
                alu_res_s = {{MW{1'b0}}, ge_s};
            end
            SM_RSVD: begin
                alu_res_s = {WIDTH{1'b0}};
            end
            default: begin
                alu_res_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Capture a new result only on accepted inputs; otherwise hold.
    always_comb begin
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d = alu_res_s;
            of_d     = alu_of_s;
        end else begin
            result_d = result_q;
            of_d     = of_q;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= {WIDTH{1'b0}};
            of_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            of_q        <= of_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign of        = of_q;
    assign out_valid = out_valid_q;

endmodule : sm_arith_unit

// File: tb/tb_sm_arith_unit.sv
// Self-checking bench for sm_arith_unit (WIDTH=4): directed vectors, full
// operand sweeps and randomized traffic against a signed-value reference model.
module tb_sm_arith_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic         of;

    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    int           fail_cnt = 0;
    logic [W-1:0] exp_res  = '0;
    logic         exp_of   = 1'b0;

    sm_arith_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .of        (of)
    );

    always #5 clk = ~clk;

    // Reference: work with signed integer values, then re-encode. Returns {of, result}.
    function automatic logic [W:0] ref_model(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        int lim = (1 << (W - 1)) - 1;
        int mx  = x[W-2:0];
        int my  = y[W-2:0];
        int va, vb, s, mag;
        logic neg, ovf;
        va = x[W-1] ? -mx : mx;
        vb = y[W-1] ? -my : my;
        case (o)
            2'd0, 2'd1: begin
                if (o == 2'd1) vb = -vb;
                s   = va + vb;
                neg = (s < 0);
                mag = neg ? -s : s;
                ovf = (mag > lim);
                if (ovf) begin
`ifdef SM_SATURATE_EN
                    mag = lim;
`else
                    mag = mag - (lim + 1);
`endif
                end
                if (mag == 0) neg = 1'b0;
                return {ovf, neg, mag[W-2:0]};
            end
            2'd2:    return {1'b0, {(W-1){1'b0}}, (mx >= my)};
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chk_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, then compare all outputs against the model.
    task automatic step(input logic v, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        if (v) {exp_of, exp_res} = ref_model(o, x, y);
        check($sformatf("out_valid op=%0d a=%b b=%b", o, x, y), out_valid, v);
        check($sformatf("result op=%0d a=%b b=%b", o, x, y), result, exp_res);
        check($sformatf("of op=%0d a=%b b=%b", o, x, y), of, exp_of);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 2'd0;
        a        = '0;
        b        = '0;
        #12;
        check("reset_result", result, 4'b0000);
        check("reset_of", of, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived constants
        step(1'b1, 2'd0, 4'b0011, 4'b0010);
        check("add_p3_p2", result, 4'b0101);
        check("add_p3_p2_of", of, 1'b0);
        step(1'b1, 2'd0, 4'b0101, 4'b0100);
        check("add_p5_p4_of", of, 1'b1);
`ifdef SM_SATURATE_EN
        check("add_p5_p4_sat", result, 4'b0111);
`else
        check("add_p5_p4_wrap", result, 4'b0001);
`endif
        step(1'b1, 2'd0, 4'b0011, 4'b1101);
        check("add_p3_m5", result, 4'b1010);
        step(1'b1, 2'd0, 4'b0011, 4'b1011);
        check("add_p3_m3_no_negzero", result, 4'b0000);
        step(1'b1, 2'd0, 4'b1000, 4'b1000);
        check("add_m0_m0", result, 4'b0000);
        step(1'b1, 2'd1, 4'b1010, 4'b1110);
        check("sub_m2_m6", result, 4'b0100);
        step(1'b1, 2'd1, 4'b0111, 4'b1001);
        check("sub_p7_m1_of", of, 1'b1);
        step(1'b1, 2'd2, 4'b0101, 4'b1101);
        check("ge_5_5", result, 4'b0001);
        step(1'b1, 2'd2, 4'b1010, 4'b0110);
        check("ge_2_6", result, 4'b0000);
        step(1'b0, 2'd0, 4'b0111, 4'b0111);
        check("hold_result", result, 4'b0000);
        step(1'b1, 2'd3, 4'b0111, 4'b0111);
        check("rsvd_result", result, 4'b0000);

        // Exhaustive back-to-back sweep of every op and operand pair
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 256; i++) begin
                step(1'b1, o[1:0], i[7:4], i[3:0]);
            end
        end

        // Randomized traffic with gaps in in_valid
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom));
        end

        // Reset in the middle of a stream: outputs clear immediately
        step(1'b1, 2'd0, 4'b0011, 4'b0010);
        in_valid = 1'b1;
        op       = 2'd0;
        a        = 4'b0110;
        b        = 4'b0001;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_result", result, 4'b0000);
        check("midrst_of", of, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_hold_result", result, 4'b0000);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_res  = '0;
        exp_of   = 1'b0;
        step(1'b0, 2'd0, 4'b0111, 4'b0111);
        step(1'b0, 2'd1, 4'b0101, 4'b1100);
        check("post_rst_zero", result, 4'b0000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_sm_arith_unit
